frame_draw_scheduler: RTL and testbench

// - Per-frame sequencer for the sprite drawers (draw_ship, draw_asteroid, draw_shot).
// - On each frame_tick: snapshot the entity tables, erase every slot active last frame, then draw every slot active now.
// - Drives one drawer at a time, so only one drawer owns the VGA plot port.
// - drv_sel steers the downstream x/y/color/plot mux.

---
 rtl/draw_pkg.sv | 18 +
 rtl/slot_decoder.sv | 20 ++
 rtl/frame_draw_scheduler.sv | 134 +++++++++++++
 tb/tb_frame_draw_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// draw_pkg: entity word fields, drawer one-hot encodings and scheduler state codes
// shared by the frame draw scheduler and its slot decoder.
package draw_pkg;
   localparam int E_ACTIVE = 33;
   localparam int E_Y_LSB  = 16;
   localparam int E_X_LSB  = 6;
   localparam logic [2:0] D_NONE     = 3'b000;
   localparam logic [2:0] D_SHIP     = 3'b100;
   localparam logic [2:0] D_ASTEROID = 3'b010;
   localparam logic [2:0] D_SHOT     = 3'b001;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_SNAP  = 3'd1;
   localparam state_t S_ISSUE = 3'd2;
   localparam state_t S_WAIT  = 3'd3;
   localparam state_t S_NEXT  = 3'd4;
   localparam state_t S_DONE  = 3'd5;
endpackage

// File: rtl/slot_decoder.sv
// slot_decoder: maps a scheduler slot index to its drawer class and its word offset
// inside the snapshot {ship, asteroid, shot}, where shots occupy the low words.
module slot_decoder
   import draw_pkg::*;
#(
   parameter int MAX_SHIPS     = 1,
   parameter int MAX_ASTEROIDS = 5,
   parameter int MAX_SHOTS     = 10,
   parameter int IW            = 4
) (
   input  logic [IW-1:0] idx,
   output logic [2:0]    cls,
   output logic [IW-1:0] off
);
   localparam int AB = MAX_SHIPS + MAX_ASTEROIDS;
   assign cls = int'(idx) < MAX_SHIPS ? D_SHIP : int'(idx) < AB ? D_ASTEROID : D_SHOT;
   assign off = cls == D_SHIP     ? IW'(int'(idx) + MAX_ASTEROIDS + MAX_SHOTS) :
                cls == D_ASTEROID ? IW'(int'(idx) - MAX_SHIPS + MAX_SHOTS) :
                                    IW'(int'(idx) - AB);
endmodule

// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: per-frame sequencer that erases last frame's sprites and draws
// this frame's, handing the plot port to one drawer at a time.
module frame_draw_scheduler
   import draw_pkg::*;
#(
   parameter int ENTITY_SIZE   = 34,
   parameter int MAX_SHIPS     = 1,
   parameter int MAX_ASTEROIDS = 5,
   parameter int MAX_SHOTS     = 10,
   parameter int TIMEOUT       = 4095
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               frame_tick,
   input  logic [MAX_SHIPS*ENTITY_SIZE-1:0]     ship_reg,
   input  logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroid_reg,
   input  logic [MAX_SHOTS*ENTITY_SIZE-1:0]     shot_reg,
   input  logic [2:0]                         drv_done,
   output logic [2:0]                         drv_start,
   output logic [2:0]                         drv_sel,
   output logic [ENTITY_SIZE-1:0]             drv_entity,
   output logic                               drv_erase,
   output logic                               busy,
   output logic                               frame_done,
   output logic                               overrun,
   output logic                               timeout_err
);
   localparam int N  = MAX_SHIPS + MAX_ASTEROIDS + MAX_SHOTS;
   localparam int IW = $clog2(N);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int NB = N * ENTITY_SIZE;
   state_t               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 pass_q, pass_d;
   logic [NB-1:0]        cur_q, cur_d, prev_q, prev_d;
   logic [TW-1:0]        cnt_q, cnt_d;
   logic                 pending_q, pending_d, overrun_q, overrun_d, timeout_q, timeout_d;
   logic [2:0]           cls;
   logic [IW-1:0]        off;
   logic [ENTITY_SIZE-1:0] word;
   logic                 act, hold, done_hit, last;
   slot_decoder #(
      .MAX_SHIPS(MAX_SHIPS), .MAX_ASTEROIDS(MAX_ASTEROIDS), .MAX_SHOTS(MAX_SHOTS), .IW(IW)
   ) u_dec (
      .idx(idx_q), .cls(cls), .off(off)
   );
   // pass_q: 0 = erase from prev, 1 = draw from cur
   assign word       = pass_q ? cur_q[int'(off)*ENTITY_SIZE +: ENTITY_SIZE]
                              : prev_q[int'(off)*ENTITY_SIZE +: ENTITY_SIZE];
   assign act        = word[E_ACTIVE];
   assign hold       = (state_q == S_ISSUE || state_q == S_WAIT) && act;
   assign done_hit   = |(drv_done & cls);
   assign last       = idx_q == IW'(N - 1);
   assign drv_start  = (state_q == S_ISSUE && act) ? cls : D_NONE;
   assign drv_sel    = hold ? cls : D_NONE;
   assign drv_entity = hold ? word : '0;
   assign drv_erase  = hold & ~pass_q;
   assign busy       = state_q != S_IDLE;
   assign frame_done = state_q == S_DONE;
   assign overrun    = overrun_q;
   assign timeout_err = timeout_q;
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pass_d    = pass_q;
      cur_d     = cur_q;
      prev_d    = prev_q;
      cnt_d     = cnt_q;
      pending_d = pending_q | (frame_tick & (state_q != S_IDLE));
      overrun_d = overrun_q | (frame_tick & pending_q);
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE: if (frame_tick || pending_q) begin
            state_d   = S_SNAP;
            pending_d = 1'b0;
         end
         S_SNAP: begin
            cur_d   = {ship_reg, asteroid_reg, shot_reg};
            idx_d   = '0;
            pass_d  = 1'b0;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            cnt_d   = TW'(1);
            state_d = act ? S_WAIT : S_NEXT;
         end
         // the watchdog counts every cycle the drawer owns the port, ISSUE included
         S_WAIT: begin
            cnt_d = cnt_q + TW'(1);
            if (done_hit) state_d = S_NEXT;
            else if (cnt_q >= TW'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = S_NEXT;
            end
         end
         S_NEXT: if (!last) begin
            idx_d   = idx_q + IW'(1);
            state_d = S_ISSUE;
         end else if (!pass_q) begin
            idx_d   = '0;
            pass_d  = 1'b1;
            state_d = S_ISSUE;
         end else begin
            prev_d  = cur_q;
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         pass_q    <= 1'b0;
         cur_q     <= '0;
         prev_q    <= '0;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pass_q    <= pass_d;
         cur_q     <= cur_d;
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler: scoreboarded directed test of the frame draw scheduler with
// behavioural drawers that answer each start with a done pulse five cycles later.
module tb_frame_draw_scheduler;
   import draw_pkg::*;
   localparam int ES = 34, NS = 1, NA = 5, NH = 10, N = 16, TO = 15;
   typedef struct packed {
      logic [2:0]    sel;
      logic [ES-1:0] ent;
      logic          erase;
   } exp_t;
   logic clk = 1'b0, reset_n = 1'b0, frame_tick = 1'b0;
   logic [NS*ES-1:0] ship_reg;
   logic [NA*ES-1:0] asteroid_reg;
   logic [NH*ES-1:0] shot_reg;
   logic [2:0] drv_done, drv_start, drv_sel, hang;
   logic [ES-1:0] drv_entity;
   logic drv_erase, busy, frame_done, overrun, timeout_err;
   logic [ES-1:0] ent [N];
   logic [ES-1:0] prev_m [N];
   exp_t sb [$];
   int dcnt [3];
   int checks = 0, errors = 0, fd_count = 0, ast_run = 0, ast_len = 0;
   always #5 clk = ~clk;
   frame_draw_scheduler #(
      .ENTITY_SIZE(ES), .MAX_SHIPS(NS), .MAX_ASTEROIDS(NA), .MAX_SHOTS(NH), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
      .ship_reg(ship_reg), .asteroid_reg(asteroid_reg), .shot_reg(shot_reg),
      .drv_done(drv_done), .drv_start(drv_start), .drv_sel(drv_sel),
      .drv_entity(drv_entity), .drv_erase(drv_erase), .busy(busy),
      .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
   );
   assign ship_reg = ent[0];
   for (genvar a = 0; a < NA; a++) begin : g_ast
      assign asteroid_reg[a*ES +: ES] = ent[1+a];
   end
   for (genvar s = 0; s < NH; s++) begin : g_shot
      assign shot_reg[s*ES +: ES] = ent[1+NA+s];
   end
   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [2:0] cls_of(int i);
      return i < NS ? 3'b100 : i < NS + NA ? 3'b010 : 3'b001;
   endfunction
   function automatic logic [ES-1:0] mk(int x, int y, int dir);
      logic [ES-1:0] e = '0;
      e[33] = 1'b1;
      e[25:16] = 10'(y);
      e[15:6] = 10'(x);
      e[5:0] = 6'(dir);
      return e;
   endfunction
   task automatic push_frame();
      for (int i = 0; i < N; i++) if (prev_m[i][E_ACTIVE]) sb.push_back('{cls_of(i), prev_m[i], 1'b1});
      for (int i = 0; i < N; i++) if (ent[i][E_ACTIVE]) sb.push_back('{cls_of(i), ent[i], 1'b0});
      for (int i = 0; i < N; i++) prev_m[i] = ent[i];
   endtask
   task automatic pulse_tick();
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask
   task automatic wait_frames(int target, string tag);
      int n = 0;
      while (fd_count < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(fd_count >= target), 64'(1));
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
   endtask
   always @(negedge clk) begin
      drv_done = 3'b000;
      for (int c = 0; c < 3; c++) begin
         if (dcnt[c] > 0) begin
            dcnt[c]--;
            if (dcnt[c] == 0 && !hang[c]) drv_done[c] = 1'b1;
         end
         if (drv_start[c]) dcnt[c] = 5;
      end
   end
   always @(negedge clk) begin
      if (frame_done) fd_count++;
      if (drv_sel == 3'b010) ast_run++;
      else begin
         if (ast_run != 0) ast_len = ast_run;
         ast_run = 0;
      end
      if (drv_start != 3'b000) begin
         if (sb.size() == 0) check("unexpected_start", 64'(drv_start), 64'(0));
         else begin
            exp_t e;
            e = sb.pop_front();
            check("start", 64'(drv_start), 64'(e.sel));
            check("sel", 64'(drv_sel), 64'(e.sel));
            check("entity", 64'(drv_entity), 64'(e.ent));
            check("erase", 64'(drv_erase), 64'(e.erase));
         end
      end
   end
   initial begin
      hang = 3'b000;
      for (int i = 0; i < N; i++) begin
         ent[i] = '0;
         prev_m[i] = '0;
      end
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_start", 64'(drv_start), 64'(0));
      check("rst_sel", 64'(drv_sel), 64'(0));
      check("rst_entity", 64'(drv_entity), 64'(0));
      check("rst_flags", 64'({frame_done, overrun, timeout_err, drv_erase}), 64'(0));
      reset_n = 1'b1;
      @(negedge clk);
      // 1: only the ship, empty erase pass
      ent[0] = mk(10, 50, 3);
      push_frame();
      pulse_tick();
      wait_frames(1, "t1_frame");
      check("t1_idle", 64'(busy), 64'(0));
      // 2: ship moves, erase at old x then draw at new x; mid-frame edits ignored
      ent[0] = mk(20, 50, 3);
      push_frame();
      pulse_tick();
      check("t2_snap_busy", 64'(busy), 64'(1));
      check("t2_snap_nostart", 64'(drv_start), 64'(0));
      @(negedge clk);
      check("t2_lat_start", 64'(drv_start), 64'(3'b100));
      check("t2_lat_x", 64'(drv_entity[15:6]), 64'(10));
      ent[1] = mk(99, 99, 1);
      wait_frames(2, "t2_frame");
      // 3: ship, asteroid 2, shot 7
      for (int i = 0; i < N; i++) ent[i] = '0;
      ent[0] = mk(30, 40, 0);
      ent[1+2] = mk(100, 200, 5);
      ent[1+NA+7] = mk(300, 150, 9);
      push_frame();
      pulse_tick();
      wait_frames(3, "t3_frame");
      check("t3_no_timeout", 64'(timeout_err), 64'(0));
      // 4: asteroid drawer hangs
      hang = 3'b010;
      push_frame();
      pulse_tick();
      wait_frames(4, "t4_frame");
      check("t4_timeout", 64'(timeout_err), 64'(1));
      check("t4_hold_len", 64'(ast_len), 64'(TO));
      hang = 3'b000;
      // 5: two extra ticks while busy
      check("t5_no_overrun", 64'(overrun), 64'(0));
      push_frame();
      push_frame();
      pulse_tick();
      repeat (8) @(negedge clk);
      pulse_tick();
      check("t5_pending_no_overrun", 64'(overrun), 64'(0));
      repeat (3) @(negedge clk);
      pulse_tick();
      check("t5_overrun", 64'(overrun), 64'(1));
      wait_frames(6, "t5_frames");
      repeat (120) @(negedge clk);
      check("t5_one_extra", 64'(fd_count), 64'(6));
      check("t5_idle", 64'(busy), 64'(0));
      // 6: reset while a drawer is busy
      sb.push_back('{3'b100, prev_m[0], 1'b1});
      pulse_tick();
      begin
         int n = 0;
         while (drv_sel == 3'b000 && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("t6_owner", 64'(drv_sel), 64'(3'b100));
      end
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("t6_start_drop", 64'(drv_start), 64'(0));
      check("t6_sel_drop", 64'(drv_sel), 64'(0));
      check("t6_entity_drop", 64'(drv_entity), 64'(0));
      check("t6_flags_drop", 64'({busy, overrun, timeout_err, drv_erase}), 64'(0));
      check("t6_sb_empty", 64'(sb.size()), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < N; i++) prev_m[i] = '0;
      @(negedge clk);
      push_frame();
      pulse_tick();
      wait_frames(fd_count + 1, "t6_frame");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
